// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: active-low glyph
// patterns (segment a in bit 0 ... g in bit 6, decimal point in bit 7) and
// a sizing helper for counters.
package display_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bits needed to hold the values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-7-segment decoder with decimal point and blanking.
// All outputs are active-low; blank forces every segment off.
module hex7seg_dec
    import display_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       point,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] glyph;

    // Look up the glyph, then overlay the decimal point and blanking.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        glyph = SEG_BLANK;
        case (hex)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
            default: glyph = SEG_BLANK;
        endcase
        seg = blank ? SEG_BLANK : {glyph[7] & ~point, glyph[6:0]};
    end

endmodule

// File: rtl/display_scan_n.sv
// N-digit multiplexed common-anode 7-segment driver. Inputs are captured
// once per frame into shadow registers so a frame never shows a mix of old
// and new values. Each digit slot starts with one dark cycle (dead time)
// to avoid ghosting; the rest of the slot is gated by PWM brightness,
// per-digit enable/blink and leading-zero blanking. Outputs are registered.
module display_scan_n
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 131072,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] hexs,
    input  logic [N_DIGITS-1:0]   points,
    input  logic [N_DIGITS-1:0]   LEs,
    input  logic [N_DIGITS-1:0]   blink,
    input  logic [PWM_BITS-1:0]   brightness,
    input  logic                  lz_blank,
    output logic [N_DIGITS-1:0]   AN,
    output logic [7:0]            SEGMENT,
    output logic                  frame_pulse
);

    localparam int IDX_W = width_of(N_DIGITS);
    localparam int CNT_W = width_of(SCAN_DIV);
    localparam int BLK_W = width_of(BLINK_FRAMES);

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

    // Scan position.
    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic             capture;

    // Blink timing.
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;

    // Frame-stable copies of the inputs.
    logic [4*N_DIGITS-1:0] sh_hexs;
    logic [N_DIGITS-1:0]   sh_points;
    logic [N_DIGITS-1:0]   sh_les;
    logic [N_DIGITS-1:0]   sh_blink;
    logic [PWM_BITS-1:0]   sh_brightness;
    logic                  sh_lz;

    // Per-slot decisions.
    logic [N_DIGITS-1:0] lz_mask;
    logic                zero_run;
    logic [3:0]          cur_hex;
    logic                cur_point;
    logic                pwm_on;
    logic                lit;
    logic [N_DIGITS-1:0] an_next;
    logic [7:0]          seg_next;

    // A new frame starts at the dead cycle of digit 0.
    assign capture = (scan_cnt == '0) && (digit_idx == '0);

    // Slot counter and digit rotation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

    // Blink half-period counter, advanced once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (capture) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // Shadow capture at the start of each frame.
    always_ff @(posedge clk) begin
        // NOTE: shadow registers are reset so the first frame after reset never decodes unknown data.
        if (rst) begin
            sh_hexs       <= '0;
            sh_points     <= '0;
            sh_les        <= '0;
            sh_blink      <= '0;
            sh_brightness <= '0;
            sh_lz         <= 1'b0;
        end else if (capture) begin
            sh_hexs       <= hexs;
            sh_points     <= points;
            sh_les        <= LEs;
            sh_blink      <= blink;
            sh_brightness <= brightness;
            sh_lz         <= lz_blank;
        end
    end

    // Leading-zero mask: walk down from the top digit while digits are empty.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (sh_hexs[4*k +: 4] == 4'h0) & ~sh_points[k];
            if (k != 0) begin
                lz_mask[k] = zero_run & sh_lz;
            end
        end
    end

    // Decide whether the current digit is lit in this cycle.
    always_comb begin
        cur_hex   = sh_hexs[{digit_idx, 2'b00} +: 4];
        cur_point = sh_points[digit_idx];
        pwm_on    = (scan_cnt[PWM_BITS-1:0] <= sh_brightness);
        lit       = (scan_cnt != '0) && pwm_on
                    && !sh_les[digit_idx]
                    && !(sh_blink[digit_idx] && blink_phase)
                    && !lz_mask[digit_idx];
        an_next   = lit ? ~(N_DIGITS'(1) << digit_idx) : '1;
    end

    hex7seg_dec u_dec (
        .hex   (cur_hex),
        .point (cur_point),
        .blank (~lit),
        .seg   (seg_next)
    );

    // Registered pin drivers and frame strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            AN          <= '1;
            SEGMENT     <= SEG_BLANK;
            frame_pulse <= 1'b0;
        end else begin
            AN          <= an_next;
            SEGMENT     <= seg_next;
            frame_pulse <= capture;
        end
    end

endmodule

// File: tb/tb_display_scan_n.sv
// Self-checking bench for display_scan_n. A behavioural model derives the
// expected pins from the cycle number since reset and the inputs present
// at each frame's capture cycle.
module tb_display_scan_n;

    localparam int N     = 4;
    localparam int DIV   = 16;
    localparam int PB    = 2;
    localparam int BF    = 2;
    localparam int FRAME = N * DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   hexs;
    logic [3:0]    points, les, blink;
    logic [1:0]    brightness;
    logic          lz_blank;
    logic [3:0]    AN;
    logic [7:0]    SEGMENT;
    logic          frame_pulse;

    typedef struct {
        logic [15:0] hexs;
        logic [3:0]  points;
        logic [3:0]  les;
        logic [3:0]  blink;
        logic [1:0]  br;
        logic        lz;
    } frame_t;

    frame_t     frames [256];
    logic [7:0] glyph  [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int cyc;
    int checks = 0;
    int errors = 0;

    display_scan_n #(
        .N_DIGITS(N), .SCAN_DIV(DIV), .PWM_BITS(PB), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .hexs(hexs), .points(points), .LEs(les),
        .blink(blink), .brightness(brightness), .lz_blank(lz_blank),
        .AN(AN), .SEGMENT(SEGMENT), .frame_pulse(frame_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit model_lz(frame_t fr, int k);
        int msd = 0;
        for (int j = 0; j < N; j++)
            if (fr.hexs[4*j +: 4] != 4'h0 || fr.points[j]) msd = j;
        return fr.lz && (k > msd);
    endfunction

    function automatic bit model_lit(int c);
        int p = c - 1;
        int s = p % DIV;
        int k = (p / DIV) % N;
        int f = p / FRAME;
        frame_t fr = frames[f % 256];
        bit phase = ((f + 1) / BF) % 2 == 1;
        return (s != 0) && ((s % (1 << PB)) <= int'(fr.br)) && !fr.les[k]
               && !(fr.blink[k] && phase) && !model_lz(fr, k);
    endfunction

    function automatic logic [3:0] exp_an(int c);
        int k = ((c - 1) / DIV) % N;
        return model_lit(c) ? ~(4'b0001 << k) : 4'hF;
    endfunction

    function automatic logic [7:0] exp_seg(int c);
        int k = ((c - 1) / DIV) % N;
        frame_t fr = frames[((c - 1) / FRAME) % 256];
        logic [7:0] g = glyph[fr.hexs[4*k +: 4]];
        if (fr.points[k]) g[7] = 1'b0;
        return model_lit(c) ? g : 8'hFF;
    endfunction

    function automatic logic exp_fp(int c);
        return (c % FRAME) == 1;
    endfunction

    // Advance one clock: record inputs at the capture cycle, then sample at negedge.
    task automatic tick();
        if (cyc % FRAME == 0)
            frames[(cyc / FRAME) % 256] = '{hexs, points, les, blink, brightness, lz_blank};
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    function automatic int next_frame();
        return (cyc + FRAME - 1) / FRAME;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        hexs = 16'h1A30; points = '0; les = '0; blink = '0; brightness = 2'd3; lz_blank = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++;
        if (AN !== 4'hF || SEGMENT !== 8'hFF || frame_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: AN=%h SEG=%h fp=%b, want F FF 0", AN, SEGMENT, frame_pulse);
        end
        rst = 1'b0; cyc = 0;
        tick();
        checks++;
        if (frame_pulse !== 1'b1 || AN !== 4'hF) begin
            errors++;
            $display("FAIL first_frame_pulse: fp=%b AN=%h, want 1 F", frame_pulse, AN);
        end
        tick();
        checks++;
        if (AN !== 4'hE || SEGMENT !== 8'hC0) begin
            errors++;
            $display("FAIL first_lit: AN=%h SEG=%h, want E C0", AN, SEGMENT);
        end
        while (cyc < 3 * FRAME) begin
            tick();
            checks++;
            if (AN !== exp_an(cyc) || SEGMENT !== exp_seg(cyc) || frame_pulse !== exp_fp(cyc)) begin
                errors++;
                $display("FAIL reset_scan c=%0d: AN=%h SEG=%h fp=%b, want %h %h %b",
                         cyc, AN, SEGMENT, frame_pulse, exp_an(cyc), exp_seg(cyc), exp_fp(cyc));
            end
        end
    endtask

    task automatic test_points();
        int tf;
        int bad = 0;
        hexs = 16'h0000; points = 4'b0001; brightness = 2'd3;
        tf = next_frame();
        while (cyc < (tf + 1) * FRAME) begin
            tick();
            checks++;
            if (AN !== exp_an(cyc) || SEGMENT !== exp_seg(cyc) || frame_pulse !== exp_fp(cyc)) begin
                errors++;
                $display("FAIL points c=%0d: AN=%h SEG=%h fp=%b, want %h %h %b",
                         cyc, AN, SEGMENT, frame_pulse, exp_an(cyc), exp_seg(cyc), exp_fp(cyc));
            end
            if ((cyc - 1) / FRAME == tf && AN == 4'hE && SEGMENT != 8'h40) bad++;
            if ((cyc - 1) / FRAME == tf && AN != 4'hE && AN != 4'hF && SEGMENT != 8'hC0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL points_glyph: %0d wrong cycles, want 0", bad);
        end
        points = '0;
    endtask

    task automatic test_lz();
        int tf;
        int upper = 0, others = 0, d0 = 0;
        lz_blank = 1'b1; hexs = 16'h0050;
        tf = next_frame();
        while (cyc < (tf + 1) * FRAME) begin
            tick();
            checks++;
            if (AN !== exp_an(cyc) || SEGMENT !== exp_seg(cyc) || frame_pulse !== exp_fp(cyc)) begin
                errors++;
                $display("FAIL lz_0050 c=%0d: AN=%h SEG=%h fp=%b, want %h %h %b",
                         cyc, AN, SEGMENT, frame_pulse, exp_an(cyc), exp_seg(cyc), exp_fp(cyc));
            end
            if ((cyc - 1) / FRAME == tf && AN[3:2] != 2'b11) upper++;
        end
        checks++;
        if (upper !== 0) begin
            errors++;
            $display("FAIL lz_upper_dark: %0d lit cycles on digits 3/2, want 0", upper);
        end
        hexs = 16'h0000;
        tf = next_frame();
        while (cyc < (tf + 1) * FRAME) begin
            tick();
            checks++;
            if (AN !== exp_an(cyc) || SEGMENT !== exp_seg(cyc) || frame_pulse !== exp_fp(cyc)) begin
                errors++;
                $display("FAIL lz_0000 c=%0d: AN=%h SEG=%h fp=%b, want %h %h %b",
                         cyc, AN, SEGMENT, frame_pulse, exp_an(cyc), exp_seg(cyc), exp_fp(cyc));
            end
            if ((cyc - 1) / FRAME == tf) begin
                if (AN == 4'hE && SEGMENT == 8'hC0) d0++;
                else if (AN != 4'hF) others++;
            end
        end
        checks++;
        if (d0 !== 15 || others !== 0) begin
            errors++;
            $display("FAIL lz_only_digit0: d0=%0d others=%0d, want 15 0", d0, others);
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_pwm();
        int tf;
        int lit_cnt = 0;
        hexs = 16'h4B7E; brightness = 2'd1;
        tf = next_frame();
        while (cyc < (tf + 1) * FRAME) begin
            tick();
            checks++;
            if (AN !== exp_an(cyc) || SEGMENT !== exp_seg(cyc) || frame_pulse !== exp_fp(cyc)) begin
                errors++;
                $display("FAIL pwm c=%0d: AN=%h SEG=%h fp=%b, want %h %h %b",
                         cyc, AN, SEGMENT, frame_pulse, exp_an(cyc), exp_seg(cyc), exp_fp(cyc));
            end
            if ((cyc - 1) / FRAME == tf && AN != 4'hF) lit_cnt++;
        end
        checks++;
        if (lit_cnt !== 4 * 7) begin
            errors++;
            $display("FAIL pwm_duty: %0d lit cycles per frame, want 28", lit_cnt);
        end
        brightness = 2'd3;
    endtask

    task automatic test_blink();
        int tf;
        int d2 = 0, d0 = 0;
        hexs = 16'h9876; blink = 4'b0100;
        tf = next_frame();
        while (cyc < (tf + 4) * FRAME) begin
            tick();
            checks++;
            if (AN !== exp_an(cyc) || SEGMENT !== exp_seg(cyc) || frame_pulse !== exp_fp(cyc)) begin
                errors++;
                $display("FAIL blink c=%0d: AN=%h SEG=%h fp=%b, want %h %h %b",
                         cyc, AN, SEGMENT, frame_pulse, exp_an(cyc), exp_seg(cyc), exp_fp(cyc));
            end
            if ((cyc - 1) / FRAME >= tf && AN == 4'hB) d2++;
            if ((cyc - 1) / FRAME >= tf && AN == 4'hE) d0++;
        end
        checks++;
        if (d2 !== 2 * 15 || d0 !== 4 * 15) begin
            errors++;
            $display("FAIL blink_duty: digit2=%0d digit0=%0d over 4 frames, want 30 60", d2, d0);
        end
        blink = '0;
    endtask

    task automatic test_back_to_back();
        int tf;
        int old_bad = 0, new_bad = 0;
        hexs = 16'h1111;
        tf = next_frame();
        while (cyc < tf * FRAME + 20) tick();
        hexs = 16'h2222;
        while (cyc < (tf + 2) * FRAME) begin
            tick();
            checks++;
            if (AN !== exp_an(cyc) || SEGMENT !== exp_seg(cyc) || frame_pulse !== exp_fp(cyc)) begin
                errors++;
                $display("FAIL midframe c=%0d: AN=%h SEG=%h fp=%b, want %h %h %b",
                         cyc, AN, SEGMENT, frame_pulse, exp_an(cyc), exp_seg(cyc), exp_fp(cyc));
            end
            if ((cyc - 1) / FRAME == tf && AN != 4'hF && SEGMENT != 8'hF9) old_bad++;
            if ((cyc - 1) / FRAME == tf + 1 && AN != 4'hF && SEGMENT != 8'hA4) new_bad++;
        end
        checks++;
        if (old_bad !== 0 || new_bad !== 0) begin
            errors++;
            $display("FAIL no_tearing: old=%0d new=%0d wrong cycles, want 0 0", old_bad, new_bad);
        end
        repeat (5) tick();
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (AN !== 4'hF || SEGMENT !== 8'hFF || frame_pulse !== 1'b0) begin
            errors++;
            $display("FAIL midslot_reset: AN=%h SEG=%h fp=%b, want F FF 0", AN, SEGMENT, frame_pulse);
        end
        rst = 1'b0; cyc = 0;
        while (cyc < FRAME + 2) begin
            tick();
            checks++;
            if (AN !== exp_an(cyc) || SEGMENT !== exp_seg(cyc) || frame_pulse !== exp_fp(cyc)) begin
                errors++;
                $display("FAIL restart c=%0d: AN=%h SEG=%h fp=%b, want %h %h %b",
                         cyc, AN, SEGMENT, frame_pulse, exp_an(cyc), exp_seg(cyc), exp_fp(cyc));
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 14; it++) begin
            hexs       = 16'($urandom);
            points     = 4'($urandom);
            les        = 4'($urandom) & 4'($urandom);
            blink      = 4'($urandom);
            brightness = 2'($urandom);
            lz_blank   = 1'($urandom);
            if ($urandom_range(0, 1) == 1) hexs[15:8] = 8'h00;
            if (it == 7) begin
                rst = 1'b1;
                @(posedge clk); @(negedge clk);
                checks++;
                if (AN !== 4'hF || SEGMENT !== 8'hFF || frame_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_reset: AN=%h SEG=%h fp=%b, want F FF 0", AN, SEGMENT, frame_pulse);
                end
                rst = 1'b0; cyc = 0;
            end
            repeat ($urandom_range(10, 120)) begin
                tick();
                checks++;
                if (AN !== exp_an(cyc) || SEGMENT !== exp_seg(cyc) || frame_pulse !== exp_fp(cyc)) begin
                    errors++;
                    $display("FAIL random c=%0d: AN=%h SEG=%h fp=%b, want %h %h %b",
                             cyc, AN, SEGMENT, frame_pulse, exp_an(cyc), exp_seg(cyc), exp_fp(cyc));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cyc = 0;
        @(negedge clk);
        test_reset();
        test_points();
        test_lz();
        test_pwm();
        test_blink();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
